// File: rtl/clock_display_pkg.sv
// Shared constants for the clock display: segment codes, slot indices, field limits.
package clock_display_pkg;

   localparam int unsigned SEG_W  = 7;
   localparam int unsigned VAL_W  = 6;
   localparam int unsigned BCD_W  = 4;
   localparam int unsigned IDX_W  = 3;
   localparam int unsigned DIGITS = 6;

   // Active-low segment codes, bit order g..a
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_DASH  = 7'b0111111;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

   localparam logic [IDX_W-1:0] SLOT_SEC_ONES = 3'd0;
   localparam logic [IDX_W-1:0] SLOT_SEC_TENS = 3'd1;
   localparam logic [IDX_W-1:0] SLOT_MIN_ONES = 3'd2;
   localparam logic [IDX_W-1:0] SLOT_MIN_TENS = 3'd3;
   localparam logic [IDX_W-1:0] SLOT_HR_ONES  = 3'd4;
   localparam logic [IDX_W-1:0] SLOT_HR_TENS  = 3'd5;

   localparam logic [VAL_W-1:0] MAX_SEC = 6'd59;
   localparam logic [VAL_W-1:0] MAX_MIN = 6'd59;
   localparam logic [VAL_W-1:0] MAX_HR  = 6'd23;

   function automatic logic [SEG_W-1:0] digit_to_seg(input logic [BCD_W-1:0] d);
      case (d)
         4'd0:    digit_to_seg = SEG_0;
         4'd1:    digit_to_seg = SEG_1;
         4'd2:    digit_to_seg = SEG_2;
         4'd3:    digit_to_seg = SEG_3;
         4'd4:    digit_to_seg = SEG_4;
         4'd5:    digit_to_seg = SEG_5;
         4'd6:    digit_to_seg = SEG_6;
         4'd7:    digit_to_seg = SEG_7;
         4'd8:    digit_to_seg = SEG_8;
         4'd9:    digit_to_seg = SEG_9;
         default: digit_to_seg = SEG_BLANK;
      endcase
   endfunction

endpackage

// File: rtl/clock_display_mux_bcd_split.sv
// Splits a 6-bit binary field into BCD tens/ones and flags values above the field limit.
module bcd_split
   import clock_display_pkg::*;
(
   input  logic [VAL_W-1:0] value_i,
   input  logic [VAL_W-1:0] max_i,
   output logic [BCD_W-1:0] tens_c_o,
   output logic [BCD_W-1:0] ones_c_o,
   output logic             oor_c_o
);

   always_comb begin
      tens_c_o = BCD_W'(value_i / VAL_W'(10));
      ones_c_o = BCD_W'(value_i % VAL_W'(10));
      oor_c_o  = (value_i > max_i);
   end

endmodule

// File: rtl/clock_display_mux.sv
// Six-digit multiplexed seven-segment driver for hh:mm:ss with per-frame input snapshot.
module clock_display_mux
   import clock_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV    = 100000,
   parameter bit          COLON_BLINK = 1'b1
) (
   input  logic             clk_100,
   input  logic             rst,
   input  logic [VAL_W-1:0] second,
   input  logic [VAL_W-1:0] minute,
   input  logic [VAL_W-1:0] hour,
   output logic [DIGITS-1:0] an,
   output logic [SEG_W-1:0]  seg,
   output logic              dp
);

   localparam int unsigned CNT_W = 20;
   localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(SCAN_DIV - 1);

   logic [CNT_W-1:0]  pcnt_q, pcnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [VAL_W-1:0]  s_sec_q, s_sec_d, s_min_q, s_min_d, s_hr_q, s_hr_d;
   logic [DIGITS-1:0] an_q, an_d;
   logic [SEG_W-1:0]  seg_q, seg_d;
   logic              dp_q, dp_d;

   logic              tick_c, wrap_c;
   logic [BCD_W-1:0]  sec_tens_c, sec_ones_c, min_tens_c, min_ones_c, hr_tens_c, hr_ones_c;
   logic              sec_oor_c, min_oor_c, hr_oor_c;
   logic [BCD_W-1:0]  digit_c;
   logic              digit_oor_c, dp_on_c;

   bcd_split u_sec (.value_i(s_sec_q), .max_i(MAX_SEC),
                    .tens_c_o(sec_tens_c), .ones_c_o(sec_ones_c), .oor_c_o(sec_oor_c));
   bcd_split u_min (.value_i(s_min_q), .max_i(MAX_MIN),
                    .tens_c_o(min_tens_c), .ones_c_o(min_ones_c), .oor_c_o(min_oor_c));
   bcd_split u_hr  (.value_i(s_hr_q),  .max_i(MAX_HR),
                    .tens_c_o(hr_tens_c),  .ones_c_o(hr_ones_c),  .oor_c_o(hr_oor_c));

   // Scan timing and frame-boundary snapshot
   always_comb begin
      tick_c  = (pcnt_q == PCNT_LAST);
      wrap_c  = tick_c && (idx_q == SLOT_HR_TENS);
      pcnt_d  = tick_c ? '0 : pcnt_q + CNT_W'(1);
      idx_d   = idx_q;
      s_sec_d = s_sec_q;
      s_min_d = s_min_q;
      s_hr_d  = s_hr_q;
      if (tick_c) begin
         idx_d = (idx_q == SLOT_HR_TENS) ? SLOT_SEC_ONES : idx_q + IDX_W'(1);
      end
      if (wrap_c) begin
         s_sec_d = second;
         s_min_d = minute;
         s_hr_d  = hour;
      end
   end

   // Digit select and decode; an out-of-range seconds value is treated as odd
   always_comb begin
      an_d        = '1;
      digit_c     = '0;
      digit_oor_c = 1'b0;
      seg_d       = SEG_BLANK;
      dp_on_c     = COLON_BLINK ? (!sec_oor_c && !s_sec_q[0]) : 1'b1;
      case (idx_q)
         SLOT_SEC_ONES: begin digit_c = sec_ones_c; digit_oor_c = sec_oor_c; end
         SLOT_SEC_TENS: begin digit_c = sec_tens_c; digit_oor_c = sec_oor_c; end
         SLOT_MIN_ONES: begin digit_c = min_ones_c; digit_oor_c = min_oor_c; end
         SLOT_MIN_TENS: begin digit_c = min_tens_c; digit_oor_c = min_oor_c; end
         SLOT_HR_ONES:  begin digit_c = hr_ones_c;  digit_oor_c = hr_oor_c;  end
         SLOT_HR_TENS:  begin digit_c = hr_tens_c;  digit_oor_c = hr_oor_c;  end
         default:       begin digit_c = '0;         digit_oor_c = 1'b0;      end
      endcase
      if (idx_q <= SLOT_HR_TENS) begin
         an_d[idx_q] = 1'b0;
         seg_d       = digit_oor_c ? SEG_DASH : digit_to_seg(digit_c);
      end
      dp_d = !(((idx_q == SLOT_MIN_ONES) || (idx_q == SLOT_HR_ONES)) && dp_on_c);
   end

   always_ff @(posedge clk_100) begin
      if (rst) begin
         pcnt_q  <= '0;
         idx_q   <= SLOT_SEC_ONES;
         s_sec_q <= '0;
         s_min_q <= '0;
         s_hr_q  <= '0;
         an_q    <= '1;
         seg_q   <= SEG_BLANK;
         dp_q    <= 1'b1;
      end else begin
         pcnt_q  <= pcnt_d;
         idx_q   <= idx_d;
         s_sec_q <= s_sec_d;
         s_min_q <= s_min_d;
         s_hr_q  <= s_hr_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule

// File: tb/tb_clock_display_mux.sv
// Scoreboard bench: stimulus queues expected display outputs, a negedge monitor checks them.
module tb_clock_display_mux;

   localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                          S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                          S6 = 7'b0000010, S7 = 7'b1111000, S9 = 7'b0010000,
                          SD = 7'b0111111, SB = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] sec, min, hr, sec2, min2, hr2;
   logic [5:0] an, an2;
   logic [6:0] seg, seg2;
   logic       dp, dp2;

   always #5 clk = ~clk;

   clock_display_mux #(.SCAN_DIV(4), .COLON_BLINK(1'b1)) dut (
      .clk_100(clk), .rst(rst), .second(sec), .minute(min), .hour(hr),
      .an(an), .seg(seg), .dp(dp));

   clock_display_mux #(.SCAN_DIV(4), .COLON_BLINK(1'b0)) dut2 (
      .clk_100(clk), .rst(rst), .second(sec2), .minute(min2), .hour(hr2),
      .an(an2), .seg(seg2), .dp(dp2));

   typedef struct {
      bit         sel;
      logic [5:0] an;
      logic [6:0] seg;
      logic       dp;
      string      name;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_fail = 0;

   // Monitor: one expected entry per clock, compared mid-cycle
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t       e;
         logic [5:0] a;
         logic [6:0] s;
         logic       d;
         e = q.pop_front();
         a = e.sel ? an2  : an;
         s = e.sel ? seg2 : seg;
         d = e.sel ? dp2  : dp;
         n_chk++;
         if (a !== e.an || s !== e.seg || d !== e.dp) begin
            n_fail++;
            $display("FAIL %s: got an=%b seg=%b dp=%b, required an=%b seg=%b dp=%b",
                     e.name, a, s, d, e.an, e.seg, e.dp);
         end
      end
   end

   task automatic push(input bit sel, input logic [5:0] a, input logic [6:0] s,
                       input logic d, input string nm);
      exp_t e;
      @(posedge clk);
      #1;
      e.sel = sel; e.an = a; e.seg = s; e.dp = d; e.name = nm;
      q.push_back(e);
   endtask

   task automatic slot(input bit sel, input int k, input logic [6:0] s, input logic d,
                       input int ncyc, input string nm);
      logic [5:0] a;
      a    = '1;
      a[k] = 1'b0;
      for (int c = 0; c < ncyc; c++) push(sel, a, s, d, nm);
   endtask

   task automatic frame(input bit sel, input logic [6:0] s0, input logic [6:0] s1,
                        input logic [6:0] s2, input logic [6:0] s3, input logic [6:0] s4,
                        input logic [6:0] s5, input logic [5:0] dpv, input string nm);
      slot(sel, 0, s0, dpv[0], 4, nm);
      slot(sel, 1, s1, dpv[1], 4, nm);
      slot(sel, 2, s2, dpv[2], 4, nm);
      slot(sel, 3, s3, dpv[3], 4, nm);
      slot(sel, 4, s4, dpv[4], 4, nm);
      slot(sel, 5, s5, dpv[5], 4, nm);
   endtask

   initial begin
      rst = 1'b1;
      sec = 6'd56; min = 6'd34; hr = 6'd12;
      sec2 = 6'd33; min2 = 6'd0; hr2 = 6'd0;

      for (int i = 0; i < 3; i++) push(0, 6'b111111, SB, 1'b1, "reset_hold");
      rst = 1'b0;

      // Snapshot is zero until the first wrap; dp lit in slots 2,4 (second 0 is even)
      frame(0, S0, S0, S0, S0, S0, S0, 6'b101011, "zero_frame");
      frame(0, S6, S5, S4, S3, S2, S1, 6'b101011, "steady_123456");

      // Change seconds once the frame has reached slot 2
      slot(0, 0, S6, 1'b1, 4, "midchg_before");
      slot(0, 1, S5, 1'b1, 4, "midchg_before");
      sec = 6'd57;
      slot(0, 2, S4, 1'b0, 4, "midchg_old_snap");
      slot(0, 3, S3, 1'b1, 4, "midchg_old_snap");
      slot(0, 4, S2, 1'b0, 4, "midchg_old_snap");
      slot(0, 5, S1, 1'b1, 4, "midchg_old_snap");

      slot(0, 0, S7, 1'b1, 4, "midchg_new");
      slot(0, 1, S5, 1'b1, 4, "midchg_new");
      slot(0, 2, S4, 1'b1, 4, "midchg_new_dp_odd");
      hr = 6'd25; min = 6'd7; sec = 6'd9;
      slot(0, 3, S3, 1'b1, 4, "midchg_new");
      slot(0, 4, S2, 1'b1, 4, "midchg_new_dp_odd");
      slot(0, 5, S1, 1'b1, 4, "midchg_new");

      frame(0, S9, S0, S7, S0, SD, SD, 6'b111111, "hour_oor");

      // Inputs stable across the wrap edge itself are captured
      slot(0, 0, S9, 1'b1, 4, "hour_oor_again");
      slot(0, 1, S0, 1'b1, 4, "hour_oor_again");
      slot(0, 2, S7, 1'b1, 4, "hour_oor_again");
      slot(0, 3, S0, 1'b1, 4, "hour_oor_again");
      slot(0, 4, SD, 1'b1, 4, "hour_oor_again");
      slot(0, 5, SD, 1'b1, 3, "hour_oor_again");
      hr = 6'd23; min = 6'd59; sec = 6'd60;
      slot(0, 5, SD, 1'b1, 1, "wrap_edge_old");

      frame(0, SD, SD, S9, S5, S3, S2, 6'b111111, "sec_oor_limits");

      // Reset with idx=3, pcnt=2
      slot(0, 0, SD, 1'b1, 4, "pre_reset");
      slot(0, 1, SD, 1'b1, 4, "pre_reset");
      slot(0, 2, S9, 1'b1, 4, "pre_reset");
      slot(0, 3, S5, 1'b1, 2, "pre_reset");
      rst = 1'b1;
      push(0, 6'b111111, SB, 1'b1, "midframe_reset");
      rst = 1'b0;
      slot(0, 0, S0, 1'b1, 4, "restart_slot0");
      slot(0, 1, S0, 1'b1, 4, "restart_slot1");

      // Steady-colon instance, restarted by the same reset
      slot(1, 2, S0, 1'b0, 4, "noblink_zero");
      slot(1, 3, S0, 1'b1, 4, "noblink_zero");
      slot(1, 4, S0, 1'b0, 4, "noblink_zero");
      slot(1, 5, S0, 1'b1, 4, "noblink_zero");
      frame(1, S3, S3, S0, S0, S0, S0, 6'b101011, "noblink_sec33");
      frame(1, S3, S3, S0, S0, S0, S0, 6'b101011, "noblink_sec33_again");

      @(negedge clk);
      for (int w = 0; w < 10 && q.size() > 0; w++) @(negedge clk);
      if (q.size() > 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL drain: got %0d entries left, required 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no end of test, required completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clock_display_mux.md
# clock_display_mux

Downstream display stage for the digital clock. It takes the binary `hour`, `minute` and `second` values, splits each into BCD tens and ones, and time-multiplexes six active-low seven-segment digits, one digit per scan period. All inputs are snapshotted once per scan frame so a displayed frame never mixes old and new time values.

## Interface
- `SCAN_DIV`, default 100000: `clk_100` cycles per digit slot. Legal range is 2 to 2^20−1. The default gives a 1 kHz digit rate and a ~167 Hz frame rate.
- `COLON_BLINK`, default 1: controls the separator dots. 1 means they blink with second parity. 0 means they are always lit.
- `clk_100`  in  1  system clock; the only clock in the block.
- `rst`  in  1  reset, synchronous, active-high.
- `second`  in  6  binary seconds; legal range 0–59.
- `minute`  in  6  binary minutes; legal range 0–59.
- `hour`  in  6  binary hours; legal range 0–23.
- `an`  out  6  digit enables, active-low; `an[i]` drives digit slot i.
- `seg`  out  7  segments, active-low; `seg[0]`=a through `seg[6]`=g.
- `dp`  out  1  decimal point, active-low.

## Operation
- Prescaler `pcnt` counts 0 to SCAN_DIV−1 and wraps. `tick` is asserted when `pcnt`==SCAN_DIV−1.
- Digit index `idx` is 0–5 and advances on `tick`, wrapping 5→0.
- Slot map:
  - idx 0 = second ones, idx 1 = second tens
  - idx 2 = minute ones, idx 3 = minute tens
  - idx 4 = hour ones, idx 5 = hour tens
- Snapshot registers `s_sec`, `s_min` and `s_hr` load from the inputs on the edge where `tick` is set and `idx`==5, i.e. on the 5→0 wrap. Between wraps the input ports are ignored.
- Each snapshot field is converted to BCD tens and ones.
- A field is out of range when sec>59, min>59 or hr>23. Both digits of an out-of-range field show '-' (`seg`=0111111). Other fields are unaffected.
- Segment codes, active-low, written as g..a:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- `dp` is asserted (0) only in slots 2 and 4:
  - COLON_BLINK=1: asserted when `s_sec[0]`==0.
  - COLON_BLINK=0: always asserted in those slots.
  - An out-of-range `s_sec` counts as odd, so `dp` stays off.
- Only one `an` bit is low at any time outside reset.

## Timing
- Reset, sampled on `clk_100` rising edge while `rst`=1, sets:
  - `pcnt`=0, `idx`=0, snapshots=0
  - `an`=111111, `seg`=1111111, `dp`=1
- `an`, `seg` and `dp` are registered. The values driven in cycle t+1 reflect `idx` and the snapshots in cycle t, a 1-cycle latency.
- First edge after `rst` falls: `an`=111110, `seg`=1000000 (digit '0').
- `idx` changes once every SCAN_DIV cycles. `an`, `seg` and `dp` change together and never glitch between edges.
- Input change mid-frame: the current frame keeps the old snapshot. The new value is displayed starting from slot 0 of the next frame, one output cycle after the wrap edge.
- Input change on the same edge as the wrap: the new value is captured.
- Reset mid-frame: takes effect on the next edge, whatever the values of `pcnt` and `idx`. The sequence then restarts at slot 0 with a full slot period.

## Structure
- Shared package `clock_display_pkg` holds:
  - the ten digit segment constants, `SEG_DASH` and `SEG_BLANK`
  - slot index constants `SLOT_SEC_ONES` through `SLOT_HR_TENS`
  - field limits `MAX_SEC`/`MAX_MIN`=59 and `MAX_HR`=23
- Sub-module `bcd_split` is combinational and instantiated three times:
  - input: 6-bit value and max limit
  - outputs: 4-bit tens, 4-bit ones, `oor` flag
- Top level contains the prescaler, index counter, snapshot registers, digit-select mux, segment decode and output registers.

## Test plan
- Reset: SCAN_DIV=4, hold `rst` for 3 cycles. Required: `an`=111111, `seg`=1111111, `dp`=1 throughout. One edge after release, `an`=111110 and `seg`=1000000.
- Steady 12:34:56, SCAN_DIV=4, after one wrap:
  - `an` walks 111110, 111101, …, 011111, 4 cycles each.
  - digits shown are 6,5,4,3,2,1.
  - `dp`=0 only on `an`=111011 and 101111.
- Mid-frame change: at `idx`=2 change `second` from 56 to 57. The remaining slots still show the 12:34:56 snapshot. The next frame shows '7' and '5' in slots 0 and 1, with `dp`=1 in slots 2 and 4.
- Out of range: `hour`=25, `minute`=7, `second`=9. Slots 4 and 5 show `seg`=0111111; slots 0–3 show 9,0,7,0.
- Reset at `idx`=3, `pcnt`=2: the next edge shows blank outputs. After release the bench sees slot 0 for exactly 4 cycles, then slot 1, and the snapshot is 0.
- COLON_BLINK=0 with `second`=33: `dp`=0 in slots 2 and 4 every frame.
